// File: rtl/mandel_line_scheduler.sv
// mandel_line_scheduler: hands out (x, y) pixel coordinates to NUM_ENGINES
// external Mandelbrot depth engines. It parks each engine's result in a
// per-engine slot and merges the slots round-robin into an output FIFO.
// The FIFO feeds a valid/ready pixel stream.
//
// Ports:
//   clk, reset_n              clock, async active-low reset
//   start, frame_mode         launch a line (0) or a whole frame (1), IDLE only
//   busy, line_done, frame_done  status and completion pulses
//   eng_start/eng_x/eng_y     per-engine start pulse and held coordinate
//   eng_done/eng_depth        per-engine result pulse and depth
//   out_valid/out_ready       output stream handshake (FIFO head, FWFT)
//   out_x/out_y/out_depth     output stream payload

// Per-engine lane: busy flag, held coordinate, and the result holding slot.
module mandel_eng_slot #(
  parameter int XW = 10,
  parameter int YW = 9,
  parameter int DW = 10
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          launch,
  input  logic [XW-1:0] launch_x,
  input  logic [YW-1:0] launch_y,
  input  logic          done,
  input  logic [DW-1:0] depth,
  input  logic          grant,
  output logic          pulse,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          busy,
  output logic          slot_valid,
  output logic [XW-1:0] slot_x,
  output logic [YW-1:0] slot_y,
  output logic [DW-1:0] slot_d
);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pulse      <= 1'b0;
      x          <= '0;
      y          <= '0;
      busy       <= 1'b0;
      slot_valid <= 1'b0;
      slot_x     <= '0;
      slot_y     <= '0;
      slot_d     <= '0;
    end else begin
      pulse <= launch;
      // launch is only offered to an idle lane, so it never collides with done
      if (launch) begin
        busy <= 1'b1;
        x    <= launch_x;
        y    <= launch_y;
      end else if (done && busy) begin
        busy       <= 1'b0;
        slot_valid <= 1'b1;
        slot_x     <= x;
        slot_y     <= y;
        slot_d     <= depth;
      end
      if (grant) slot_valid <= 1'b0;
    end
  end
endmodule

module mandel_line_scheduler #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int NUM_ENGINES   = 5,
  parameter int DEPTH_WIDTH   = 10,
  parameter int FIFO_DEPTH    = 16,
  parameter int XW            = $clog2(SCREEN_WIDTH),
  parameter int YW            = $clog2(SCREEN_HEIGHT)
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               start,
  input  logic                               frame_mode,
  output logic                               busy,
  output logic                               line_done,
  output logic                               frame_done,
  output logic [NUM_ENGINES-1:0]             eng_start,
  output logic [NUM_ENGINES*XW-1:0]          eng_x,
  output logic [NUM_ENGINES*YW-1:0]          eng_y,
  input  logic [NUM_ENGINES-1:0]             eng_done,
  input  logic [NUM_ENGINES*DEPTH_WIDTH-1:0] eng_depth,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [XW-1:0]                      out_x,
  output logic [YW-1:0]                      out_y,
  output logic [DEPTH_WIDTH-1:0]             out_depth
);
  localparam int N  = NUM_ENGINES;
  localparam int DW = DEPTH_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN} state_t;
  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [DW-1:0] d;
  } ent_t;

  state_t        state;
  logic          fmode;
  logic [XW-1:0] cur_x;
  logic [YW-1:0] cur_y, line_y;

  logic [N-1:0]         launch, eng_busy, slot_valid, grant, idle;
  logic [N-1:0][XW-1:0] launch_x, ex, slot_x;
  logic [N-1:0][YW-1:0] launch_y, ey, slot_y;
  logic [N-1:0][DW-1:0] ed, slot_d;

  assign eng_x = ex;
  assign eng_y = ey;
  assign ed    = eng_depth;
  assign idle  = ~eng_busy & ~slot_valid;

  for (genvar i = 0; i < N; i++) begin : g_eng
    mandel_eng_slot #(.XW(XW), .YW(YW), .DW(DW)) u_eng (
      .clk(clk), .reset_n(reset_n),
      .launch(launch[i]), .launch_x(launch_x[i]), .launch_y(launch_y[i]),
      .done(eng_done[i]), .depth(ed[i]), .grant(grant[i]),
      .pulse(eng_start[i]), .x(ex[i]), .y(ey[i]),
      .busy(eng_busy[i]), .slot_valid(slot_valid[i]),
      .slot_x(slot_x[i]), .slot_y(slot_y[i]), .slot_d(slot_d[i])
    );
  end

  // Dispatch: walk idle lanes lowest-first, handing each the next raster
  // coordinate. The start cycle itself dispatches too, so the first
  // eng_start lands together with busy.
  logic          dispatch_en, fm_sel, last_issued;
  logic [XW-1:0] nx;
  logic [YW-1:0] ny;

  always_comb begin
    dispatch_en = (state == DISPATCH) || (state == IDLE && start);
    fm_sel      = (state == IDLE) ? frame_mode : fmode;
    nx          = (state == IDLE) ? '0 : cur_x;
    ny          = (state == IDLE) ? (frame_mode ? '0 : line_y) : cur_y;
    last_issued = 1'b0;
    launch      = '0;
    launch_x    = '0;
    launch_y    = '0;
    for (int i = 0; i < N; i++) begin
      if (dispatch_en && idle[i] && !last_issued) begin
        launch[i]   = 1'b1;
        launch_x[i] = nx;
        launch_y[i] = ny;
        if (nx == XW'(SCREEN_WIDTH - 1)) begin
          if (!fm_sel || ny == YW'(SCREEN_HEIGHT - 1)) last_issued = 1'b1;
          else begin
            nx = '0;
            ny = ny + 1'b1;
          end
        end else begin
          nx = nx + 1'b1;
        end
      end
    end
  end

  // Output FIFO. A full FIFO still accepts a push when the head pops in the
  // same cycle.
  ent_t          mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   cnt;
  logic          full, pop, push, can_push;
  ent_t          head;

  assign full      = (cnt == (AW+1)'(FIFO_DEPTH));
  assign out_valid = (cnt != '0);
  assign pop       = out_valid && out_ready;
  assign can_push  = !full || out_ready;
  assign head      = mem[rptr];
  assign out_x     = out_valid ? head.x : '0;
  assign out_y     = out_valid ? head.y : '0;
  assign out_depth = out_valid ? head.d : '0;

  // Round-robin arbiter: search starts one past the previous grant.
  logic [GW-1:0] last_grant, gidx, cand;
  int            rr_idx;

  always_comb begin
    grant  = '0;
    gidx   = last_grant;
    push   = 1'b0;
    rr_idx = 0;
    cand   = '0;
    for (int k = 1; k <= N; k++) begin
      rr_idx = int'(last_grant) + k;
      if (rr_idx >= N) rr_idx = rr_idx - N;
      cand = GW'(rr_idx);
      if (!push && can_push && slot_valid[cand]) begin
        push        = 1'b1;
        grant[cand] = 1'b1;
        gidx        = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= '{x: slot_x[gidx], y: slot_y[gidx], d: slot_d[gidx]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr       <= '0;
      rptr       <= '0;
      cnt        <= '0;
      last_grant <= GW'(N - 1);
    end else begin
      if (push) begin
        wptr       <= wptr + 1'b1;
        last_grant <= gidx;
      end
      if (pop) rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  logic drained;
  assign drained = ~|eng_busy && ~|slot_valid && !out_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      line_done  <= 1'b0;
      frame_done <= 1'b0;
      fmode      <= 1'b0;
      cur_x      <= '0;
      cur_y      <= '0;
      line_y     <= '0;
    end else begin
      line_done  <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          busy  <= 1'b1;
          fmode <= frame_mode;
          cur_x <= nx;
          cur_y <= ny;
          state <= last_issued ? DRAIN : DISPATCH;
        end
        DISPATCH: begin
          cur_x <= nx;
          cur_y <= ny;
          if (last_issued) state <= DRAIN;
        end
        DRAIN: if (drained) begin
          state <= IDLE;
          busy  <= 1'b0;
          if (fmode) begin
            frame_done <= 1'b1;
            line_y     <= '0;
          end else begin
            line_done <= 1'b1;
            if (line_y == YW'(SCREEN_HEIGHT - 1)) begin
              line_y     <= '0;
              frame_done <= 1'b1;
            end else begin
              line_y <= line_y + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mandel_line_scheduler.sv
// Bench for mandel_line_scheduler: W=8, H=2, 3 engines, 4-entry FIFO.
// Engine models return depth = x+1 after a fixed or random latency; a
// scoreboard counts every popped (x, y) and compares against the set of
// coordinates a line/frame must produce.
module tb_mandel_line_scheduler;
  localparam int W  = 8;
  localparam int H  = 2;
  localparam int N  = 3;
  localparam int DW = 10;
  localparam int FD = 4;
  localparam int XW = $clog2(W);
  localparam int YW = $clog2(H);

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            start = 1'b0;
  logic            frame_mode = 1'b0;
  logic            busy, line_done, frame_done, out_valid;
  logic [N-1:0]    eng_start;
  logic [N*XW-1:0] eng_x;
  logic [N*YW-1:0] eng_y;
  logic [N-1:0]    eng_done = '0;
  logic [N*DW-1:0] eng_depth = '0;
  logic            out_ready = 1'b0;
  logic [XW-1:0]   out_x;
  logic [YW-1:0]   out_y;
  logic [DW-1:0]   out_depth;

  always #5 clk = ~clk;

  mandel_line_scheduler #(
    .SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .NUM_ENGINES(N),
    .DEPTH_WIDTH(DW), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .frame_mode(frame_mode),
    .busy(busy), .line_done(line_done), .frame_done(frame_done),
    .eng_start(eng_start), .eng_x(eng_x), .eng_y(eng_y),
    .eng_done(eng_done), .eng_depth(eng_depth),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_depth(out_depth)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int model_y = 0;
  int lat_rand = 0;
  int rdy_mode = 0;
  int start_req = 0;
  int fm_req = 0;
  int cnt [N];
  int ex [N];
  int hits [W][H];
  int npix, depth_err, n_ld, n_fd, ld_cyc, fd_cyc, n_starts;
  int order [$];
  int pop_cyc [$];

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One clock: engine models react to this cycle's eng_start, inputs are
  // driven, then outputs are sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    eng_done = '0;
    for (int i = 0; i < N; i++) begin
      if (cnt[i] > 0) begin
        cnt[i]--;
        if (cnt[i] == 0) begin
          eng_done[i] = 1'b1;
          eng_depth[i*DW +: DW] = DW'(ex[i] + 1);
        end
      end
      if (eng_start[i]) begin
        n_starts++;
        cnt[i] = lat_rand ? int'($urandom_range(20, 1)) : 4;
        ex[i]  = int'(eng_x[i*XW +: XW]);
      end
    end
    start      = (start_req != 0);
    frame_mode = (fm_req != 0);
    start_req  = 0;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(1, 0));
      default: out_ready = 1'b0;
    endcase
    #1;
    if (line_done)  begin n_ld++; ld_cyc = cyc; end
    if (frame_done) begin n_fd++; fd_cyc = cyc; end
    if (out_valid && out_ready) begin
      npix++;
      hits[out_x][out_y]++;
      if (int'(out_depth) != int'(out_x) + 1) depth_err++;
      order.push_back(int'(out_x));
      pop_cyc.push_back(cyc);
    end
  endtask

  task automatic clear_stats();
    npix = 0; depth_err = 0; n_ld = 0; n_fd = 0; ld_cyc = -1; fd_cyc = -2; n_starts = 0;
    order.delete();
    pop_cyc.delete();
    for (int x = 0; x < W; x++)
      for (int y = 0; y < H; y++) hits[x][y] = 0;
  endtask

  task automatic launch(input string tag, input int fm);
    clear_stats();
    start_req = 1;
    fm_req    = fm;
    tick();
    tick();
    chk({tag, "_busy_up"}, int'(busy), 1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_idle"}, int'(busy), 0);
  endtask

  // Reference: a line covers all x at model_y, a frame covers every (x, y);
  // each exactly once, depth = x+1. Then advance the line counter model.
  task automatic check_cov(input string tag, input int fm);
    int badc = 0;
    for (int x = 0; x < W; x++)
      for (int y = 0; y < H; y++)
        if (hits[x][y] != ((fm != 0 || y == model_y) ? 1 : 0)) badc++;
    chk({tag, "_cov"}, badc, 0);
    chk({tag, "_npix"}, npix, fm ? W*H : W);
    chk({tag, "_depth"}, depth_err, 0);
    if (fm != 0) begin
      chk({tag, "_fdone"}, n_fd, 1);
      chk({tag, "_ldone"}, n_ld, 0);
      model_y = 0;
    end else begin
      chk({tag, "_ldone"}, n_ld, 1);
      chk({tag, "_fdone"}, n_fd, (model_y == H-1) ? 1 : 0);
      if (model_y == H-1) chk({tag, "_same_cyc"}, fd_cyc, ld_cyc);
      model_y = (model_y + 1) % H;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_ldone"}, int'(line_done), 0);
    chk({tag, "_fdone"}, int'(frame_done), 0);
    chk({tag, "_estart"}, int'(eng_start), 0);
    chk({tag, "_ex"}, int'(eng_x), 0);
    chk({tag, "_ey"}, int'(eng_y), 0);
    chk({tag, "_ovalid"}, int'(out_valid), 0);
    chk({tag, "_ox"}, int'(out_x), 0);
    chk({tag, "_oy"}, int'(out_y), 0);
    chk({tag, "_od"}, int'(out_depth), 0);
  endtask

  initial begin
    int s;
    for (int i = 0; i < N; i++) begin cnt[i] = 0; ex[i] = 0; end
    clear_stats();
    repeat (3) @(posedge clk);
    #2;
    chk_zero("rst");
    @(negedge clk);
    reset_n = 1'b1;

    // line y=0: all three engines start together and finish together
    launch("l0", 0);
    chk("l0_estart", int'(eng_start), 7);
    chk("l0_ex", int'(eng_x), (2 << 6) | (1 << 3));
    wait_idle("l0", 500);
    check_cov("l0", 0);
    if (order.size() >= 4) begin
      chk("rr0", order[0], 0);
      chk("rr1", order[1], 1);
      chk("rr2", order[2], 2);
      chk("rr3", order[3], 3);
      chk("rr_cyc1", pop_cyc[1] - pop_cyc[0], 1);
      chk("rr_cyc2", pop_cyc[2] - pop_cyc[1], 1);
    end

    // line y=1 wraps the frame; then y=0 again
    launch("l1", 0);
    wait_idle("l1", 500);
    check_cov("l1", 0);
    launch("l2", 0);
    wait_idle("l2", 500);
    check_cov("l2", 0);

    // whole frame, random latency and random sink readiness
    lat_rand = 1;
    rdy_mode = 1;
    launch("fr", 1);
    wait_idle("fr", 4000);
    check_cov("fr", 1);

    // backpressure: sink stalled, 4 FIFO + 3 slots then dispatch stops
    lat_rand = 0;
    rdy_mode = 2;
    launch("bp", 0);
    repeat (60) tick();
    chk("bp_starts", n_starts, FD + N);
    chk("bp_busy", int'(busy), 1);
    chk("bp_valid", int'(out_valid), 1);
    s = n_starts;
    repeat (20) tick();
    chk("bp_nomore", n_starts, s);
    rdy_mode = 0;
    wait_idle("bp", 500);
    check_cov("bp", 0);
    chk("bp_total_starts", n_starts, W);

    // async reset in the middle of a frame
    lat_rand = 1;
    rdy_mode = 1;
    launch("mr", 1);
    repeat (15) tick();
    reset_n = 1'b0;
    #1;
    chk_zero("mr");
    eng_done = '0;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    model_y = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    lat_rand = 0;
    rdy_mode = 0;
    launch("ar", 0);
    chk("ar_ex0", int'(eng_x[XW-1:0]), 0);
    chk("ar_ey", int'(eng_y), 0);
    wait_idle("ar", 500);
    check_cov("ar", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mandel_line_scheduler.md
# mandel_line_scheduler

Parametrised pixel scheduler for the Mandelbrot datapath. It dispatches (x, y) coordinates to NUM_ENGINES external depth engines over a per-engine start/done handshake. Each engine result is captured in a per-engine holding slot, and a round-robin arbiter merges the slots into one output FIFO. That FIFO drives a valid/ready pixel stream toward the frame-buffer writer. It supports single-line and whole-frame modes, and applies lossless backpressure from the output sink back to the engines.

## Interface
- SCREEN_WIDTH, 640, pixels per line
- SCREEN_HEIGHT, 480, lines per frame
- NUM_ENGINES, 5, engine count (1..16)
- DEPTH_WIDTH, 10, iteration-depth width
- FIFO_DEPTH, 16, output FIFO entries (power of two, ≥2)
- XW, $clog2(SCREEN_WIDTH), x width (derived)
- YW, $clog2(SCREEN_HEIGHT), y width (derived)
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- start  in  1  begin a line/frame; sampled in IDLE only
- frame_mode  in  1  1 = whole frame, 0 = one line; sampled with start
- busy  out  1  high from the cycle after start until completion
- line_done  out  1  one-cycle pulse; line mode only
- frame_done  out  1  one-cycle pulse when the last line of a frame completes
- eng_start  out  NUM_ENGINES  one-cycle start pulse per engine
- eng_x  out  NUM_ENGINES*XW  per-engine x, held from eng_start until the next dispatch
- eng_y  out  NUM_ENGINES*YW  per-engine y, same hold rule
- eng_done  in  NUM_ENGINES  one-cycle pulse; eng_depth is valid in the same cycle
- eng_depth  in  NUM_ENGINES*DEPTH_WIDTH  per-engine result
- out_valid  out  1  output FIFO not empty
- out_ready  in  1  sink accepts; an entry pops when out_valid && out_ready
- out_x, out_y, out_depth  out  XW / YW / DEPTH_WIDTH  head FIFO entry (first-word fall-through)

## Operation
- FSM states:
  - IDLE → DISPATCH on start.
  - DISPATCH → DRAIN when the last coordinate has been issued. In line mode this is x = W-1. In frame mode it is (W-1, H-1).
  - DRAIN → IDLE when the block is fully drained. Fully drained means: all engines idle, all slots empty, and the FIFO empty.
- Per-engine state:
  - eng_busy[i] sets on eng_start[i] and clears on eng_done[i].
  - slot_valid[i] sets on eng_done[i], which also captures {eng_x[i], eng_y[i], eng_depth[i]}.
  - slot_valid[i] clears when the slot is granted into the FIFO.
  - Engine i is idle when !eng_busy[i] && !slot_valid[i].
- Dispatch: each DISPATCH cycle, every idle engine receives the next coordinate, lowest index first. Several engines may start in the same cycle.
  - x increments per dispatch.
  - In frame mode, x wraps W-1 → 0 and y increments.
  - Dispatch stops at the last coordinate; excess idle engines receive no start.
- Arbiter: at most one slot is written into the FIFO per cycle, and only when the FIFO is not full. Grant is round-robin, starting at the index after the last grant.
- FIFO entry is {x, y, depth}. It is written only from slots, and read only on out_valid && out_ready.
- Completion:
  - Line mode: line_done pulses once and y advances. If y was H-1, y wraps to 0 and frame_done pulses in the same cycle.
  - Frame mode: frame_done pulses once, y returns to 0, and line_done does not pulse.
- Ignored inputs:
  - start while busy.
  - eng_done[i] while eng_busy[i] = 0.
- Output order may differ from raster order; every coordinate appears exactly once.

## Timing
- Reset values:
  - All outputs are 0: busy, line_done, frame_done, eng_start, eng_x, eng_y, out_valid, out_x, out_y, out_depth.
  - Internal y = 0 and the FSM is in IDLE.
  - Reset takes effect asynchronously, mid-operation included. Slot and FIFO contents are discarded.
- start in cycle t: busy = 1 and the first eng_start pulses appear in cycle t+1.
- eng_done[i] in cycle t:
  - slot_valid[i] in t+1.
  - Earliest FIFO write at the end of t+1.
  - Earliest out_valid in t+2.
  - Earliest next eng_start[i] in t+3.
- FIFO full: slots hold, their engines stay non-idle, and no new start is issued to them; no data is lost.
- FIFO simultaneous read and write when full is allowed: pop and push occur together.
- Completion pulses come in the cycle after the drain condition holds; busy falls in that same cycle.
- A new start is accepted in the cycle after busy falls.

## Test plan
- Default setup: W=8, H=2, N=3, FIFO_DEPTH=4, engines with 4-cycle latency and depth = x+1, out_ready=1 unless stated.
- Line mode, start → eight outputs x = 0..7, y = 0, depth = x+1, each exactly once; one line_done pulse; busy = 0 afterwards.
- Second start → eight outputs with y = 1; line_done and frame_done pulse in the same cycle; the next line again uses y = 0.
- frame_mode = 1, random engine latency 1–20 → 16 unique (x, y) pairs; frame_done exactly once; line_done never pulses.
- Hold out_ready = 0 → 4 FIFO entries and 3 full slots, then no further eng_start. Release → all 8 pixels delivered with no duplicates and no losses.
- All three engines pulse eng_done in the same cycle with the FIFO empty → three FIFO writes on consecutive cycles in round-robin order. Later grants continue from the next index.
- Assert reset_n = 0 mid-frame → all outputs are 0 immediately. After release, start produces line y = 0 from x = 0.
